// File: rtl/prog_chain_loader.sv
// Word-wide loader for the configuration scan chain: serialises DATA_W-bit words LSB-first onto a
// shift-qualified chain. Optional CRC readback verify is enabled by defining PROG_CRC_EN.
module prog_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int DATA_W    = 4,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din,
    output logic              chain_en,
    output logic              chain_shift,
    output logic              chain_in,
    input  logic              chain_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int HC_W  = $clog2(DATA_W + 1);
    localparam int ACC_W = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef PROG_CRC_EN
        S_VERIFY,
        S_ERR,
`endif
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] hold_reg;
    logic [HC_W-1:0]   hold_cnt;
    logic [ACC_W-1:0]  acc_cnt;
    logic [ACC_W-1:0]  acc_sum;
    logic              all_acc;

    logic in_load;
    logic in_idle_end;
    logic start_take;
    logic load_shift;
    logic last_load_shift;
    logic accept;

    assign in_load     = (state == S_LOAD);
`ifdef PROG_CRC_EN
    assign in_idle_end = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
`else
    assign in_idle_end = (state == S_IDLE) || (state == S_DONE);
`endif
    assign start_take  = start && in_idle_end;

    // The loader is never in LOAD with bit_count==CHAIN_LEN: it leaves on the final shift edge.
    assign load_shift      = in_load && (hold_cnt != '0);
    assign last_load_shift = load_shift && (bit_count == CNT_W'(CHAIN_LEN - 1));

    assign din_ready = in_load && !all_acc && ((hold_cnt == '0) || (hold_cnt == HC_W'(1)));
    assign accept    = din_valid && din_ready;
    assign acc_sum   = acc_cnt + ACC_W'(DATA_W);

`ifdef PROG_CRC_EN
    logic [7:0] crc_load;
    logic [7:0] crc_ver;
    logic       in_verify;
    logic       ver_last;
    logic       crc_match;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign in_verify = (state == S_VERIFY);
    assign ver_last  = in_verify && (bit_count == CNT_W'(CHAIN_LEN - 1));
    assign crc_match = (crc8_step(crc_ver, chain_out) == crc_load);

    assign chain_shift = load_shift || in_verify;
    assign chain_in    = load_shift ? hold_reg[0] : (in_verify ? chain_out : 1'b0);
    assign busy        = in_load || in_verify;
    assign error       = (state == S_ERR);
`else
    logic unused_chain_out;
    assign unused_chain_out = chain_out;

    assign chain_shift = load_shift;
    assign chain_in    = load_shift ? hold_reg[0] : 1'b0;
    assign busy        = in_load;
    assign error       = 1'b0;
`endif

    assign chain_en = busy;
    assign done     = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (last_load_shift) begin
`ifdef PROG_CRC_EN
                    state_nxt = S_VERIFY;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef PROG_CRC_EN
            S_VERIFY: if (ver_last) state_nxt = crc_match ? S_DONE : S_ERR;
            S_ERR:    if (start) state_nxt = S_LOAD;
`endif
            S_DONE: if (start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            acc_cnt   <= '0;
            all_acc   <= 1'b0;
            bit_count <= '0;
        end else if (start_take) begin
            hold_cnt  <= '0;
            acc_cnt   <= '0;
            all_acc   <= 1'b0;
            bit_count <= '0;
        end else if (in_load) begin
            if (last_load_shift) begin
                // Leftover bits of the final word are dropped here.
                hold_cnt <= '0;
`ifdef PROG_CRC_EN
                bit_count <= '0;
`else
                bit_count <= bit_count + CNT_W'(1);
`endif
            end else begin
                if (accept) begin
                    hold_cnt <= HC_W'(DATA_W);
                    acc_cnt  <= acc_sum;
                    all_acc  <= (acc_sum >= ACC_W'(CHAIN_LEN));
                end else if (load_shift) begin
                    hold_cnt <= hold_cnt - HC_W'(1);
                end
                if (load_shift) bit_count <= bit_count + CNT_W'(1);
            end
        end
`ifdef PROG_CRC_EN
        else if (in_verify) begin
            bit_count <= bit_count + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_reg <= din;
        end else if (load_shift) begin
            hold_reg <= hold_reg >> 1;
        end
    end

`ifdef PROG_CRC_EN
    // Load CRC covers the bits written; verify CRC covers the same bits read back by rotation.
    always_ff @(posedge clk) begin
        if (start_take) begin
            crc_load <= 8'h00;
        end else if (load_shift) begin
            crc_load <= crc8_step(crc_load, hold_reg[0]);
        end
        if (last_load_shift) begin
            crc_ver <= 8'h00;
        end else if (in_verify) begin
            crc_ver <= crc8_step(crc_ver, chain_out);
        end
    end
`endif

endmodule

// File: tb/tb_prog_chain_loader.sv
// Bench for prog_chain_loader: random/fixed word streams against a bit-stream and chain-image model,
// on a 64-bit chain and a 10-bit chain.
module tb_prog_chain_loader;

    localparam int L  = 64;
    localparam int SL = 10;
`ifdef PROG_CRC_EN
    localparam int CRC_ON = 1;
`else
    localparam int CRC_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       din_valid = 1'b0;
    logic [3:0] din = 4'h0;
    logic       din_ready, chain_en, chain_shift, chain_in, chain_out, busy, done, error;
    logic [6:0] bit_count;

    logic         s_start = 1'b0;
    logic         s_din_valid = 1'b0;
    logic [3:0]   s_din = 4'h0;
    logic         s_din_ready, s_chain_en, s_chain_shift, s_chain_in, s_chain_out;
    logic         s_busy, s_done, s_error;
    logic [6:0]   s_bit_count;

    logic [L-1:0]  chain = '0;
    logic [SL-1:0] s_chain = '0;
    logic          stuck = 1'b0;

    assign chain_out   = stuck ? 1'b0 : chain[L-1];
    assign s_chain_out = s_chain[SL-1];

    always @(posedge clk) if (chain_shift) chain <= {chain[L-2:0], chain_in};
    always @(posedge clk) if (s_chain_shift) s_chain <= {s_chain[SL-2:0], s_chain_in};

    prog_chain_loader #(.CHAIN_LEN(L), .DATA_W(4), .CNT_W(7)) u_big (
        .clk(clk), .rst(rst), .start(start), .din_valid(din_valid), .din_ready(din_ready),
        .din(din), .chain_en(chain_en), .chain_shift(chain_shift), .chain_in(chain_in),
        .chain_out(chain_out), .busy(busy), .done(done), .error(error), .bit_count(bit_count)
    );

    prog_chain_loader #(.CHAIN_LEN(SL), .DATA_W(4), .CNT_W(7)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .din_valid(s_din_valid), .din_ready(s_din_ready),
        .din(s_din), .chain_en(s_chain_en), .chain_shift(s_chain_shift), .chain_in(s_chain_in),
        .chain_out(s_chain_out), .busy(s_busy), .done(s_done), .error(s_error),
        .bit_count(s_bit_count)
    );

    logic [3:0] words[16];
    int n_cmp = 0;
    int n_bad = 0;

    // Drives one full load on the 64-bit chain and checks it against the word-stream model.
    task automatic run_load(input int stall_after, input int stall_len, input int start_at,
                            input bit exp_err);
        int wi, held, cyc, nsh, first_sh, last_sh, gap, gap_bad, done_cyc;
        bit fin, mid_chk;
        logic [L-1:0] got, exp_s, exp_img;
        wi = 0; held = 0; cyc = 0; nsh = 0; first_sh = -1; last_sh = -1;
        gap = 0; gap_bad = 0; done_cyc = -1; fin = 0; mid_chk = 0; got = '0;
        for (int i = 0; i < L; i++) begin
            exp_s[i] = words[i/4][i%4];
            exp_img[L-1-i] = exp_s[i];
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!fin && cyc < 400) begin
            if (mid_chk) begin
                n_cmp++;
                if (int'(bit_count) !== start_at + 1 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL mid_start_ignored: bit_count=%0d busy=%0b expected %0d/1",
                             bit_count, busy, start_at + 1);
                end
                mid_chk = 0;
            end
            start = 1'b0;
            if (chain_shift) begin
                if (nsh < L) got[nsh] = chain_in;
`ifdef PROG_CRC_EN
                if (nsh == L) begin
                    n_cmp++;
                    if (bit_count !== 7'd0) begin
                        n_bad++;
                        $display("FAIL verify_count_restart: bit_count=%0d expected 0", bit_count);
                    end
                end
`endif
                if (start_at >= 0 && int'(bit_count) == start_at && nsh < L) begin
                    start = 1'b1;
                    mid_chk = 1;
                end
                if (first_sh < 0) first_sh = cyc;
                last_sh = cyc;
                nsh++;
            end else if (first_sh >= 0 && !done && !error) begin
                gap++;
                if (int'(bit_count) != stall_after * 4) gap_bad++;
            end
            if (done || error) begin
                done_cyc = cyc;
                fin = 1;
            end
            if (!fin) begin
                if (wi < 16) begin
                    if (wi == stall_after && held < stall_len) begin
                        din_valid = 1'b0;
                        if (din_ready) held++;
                    end else begin
                        din_valid = 1'b1;
                        din = words[wi];
                        if (din_ready) wi++;
                    end
                end else begin
                    din_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        din_valid = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL load_timeout: cycles=%0d expected done/error within 400", cyc);
        end
        n_cmp++;
        if (nsh != L * (1 + CRC_ON)) begin
            n_bad++;
            $display("FAIL shift_count: got %0d expected %0d", nsh, L * (1 + CRC_ON));
        end
        n_cmp++;
        if (got !== exp_s) begin
            n_bad++;
            $display("FAIL bit_stream: got %h expected %h", got, exp_s);
        end
        if (!exp_err) begin
            n_cmp++;
            if (chain !== exp_img) begin
                n_bad++;
                $display("FAIL chain_image: got %h expected %h", chain, exp_img);
            end
        end
        n_cmp++;
        if (gap != stall_len || gap_bad != 0) begin
            n_bad++;
            $display("FAIL stall_cycles: got %0d (bad count %0d) expected %0d", gap, gap_bad, stall_len);
        end
        n_cmp++;
        if (done_cyc != last_sh + 1 || (last_sh - first_sh + 1) != nsh + gap) begin
            n_bad++;
            $display("FAIL done_timing: done at %0d last shift %0d span %0d expected last+1, span %0d",
                     done_cyc, last_sh, last_sh - first_sh + 1, nsh + gap);
        end
        n_cmp++;
        if (done !== !exp_err || error !== exp_err || busy !== 1'b0 || int'(bit_count) != L) begin
            n_bad++;
            $display("FAIL end_status: done=%0b error=%0b busy=%0b bit_count=%0d expected %0b/%0b/0/%0d",
                     done, error, busy, bit_count, !exp_err, exp_err, L);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) words[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({din_ready, chain_en, chain_shift, chain_in, busy, done, error} !== 7'b0 ||
            bit_count !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_state: flags=%b bit_count=%0d expected 0/0",
                     {din_ready, chain_en, chain_shift, chain_in, busy, done, error}, bit_count);
        end
        n_cmp++;
        if ({s_din_ready, s_chain_en, s_chain_shift, s_busy, s_done, s_error} !== 6'b0 ||
            s_bit_count !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_state_small: flags=%b bit_count=%0d expected 0/0",
                     {s_din_ready, s_chain_en, s_chain_shift, s_busy, s_done, s_error}, s_bit_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 15; i++) words[i] = 4'(i + 1);
        words[15] = 4'h0;
        run_load(99, 0, -1, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 15; i++) words[i] = 4'(i + 1);
        words[15] = 4'h0;
        run_load(5, 3, -1, 1'b0);
    endtask

    task automatic test_short_chain();
        logic [3:0]    sw[3];
        logic [SL-1:0] got, exp_s, exp_img;
        int nsh, acc, cyc, ready_late;
        bit fin;
        sw[0] = 4'hF; sw[1] = 4'hA; sw[2] = 4'h3;
        for (int i = 0; i < SL; i++) begin
            exp_s[i] = sw[i/4][i%4];
            exp_img[SL-1-i] = exp_s[i];
        end
        got = '0; nsh = 0; acc = 0; cyc = 0; ready_late = 0; fin = 0;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        while (!fin && cyc < 200) begin
            if (s_chain_shift) begin
                if (nsh < SL) got[nsh] = s_chain_in;
                nsh++;
            end
            if (s_done || s_error) fin = 1;
            if (acc >= 3 && s_din_ready) ready_late++;
            if (!fin) begin
                s_din_valid = 1'b1;
                s_din = (acc < 3) ? sw[acc] : 4'h5;
                if (s_din_ready) acc++;
                @(negedge clk);
                cyc++;
            end
        end
        s_din_valid = 1'b0;
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL short_timeout: cycles=%0d expected done within 200", cyc);
        end
        n_cmp++;
        if (acc != 3 || ready_late != 0) begin
            n_bad++;
            $display("FAIL short_accept: words=%0d late ready cycles=%0d expected 3/0", acc, ready_late);
        end
        n_cmp++;
        if (nsh != SL * (1 + CRC_ON) || got !== exp_s) begin
            n_bad++;
            $display("FAIL short_stream: shifts=%0d bits=%b expected %0d/%b",
                     nsh, got, SL * (1 + CRC_ON), exp_s);
        end
        n_cmp++;
        if (s_chain !== exp_img || int'(s_bit_count) != SL || s_done !== 1'b1) begin
            n_bad++;
            $display("FAIL short_end: chain=%b bit_count=%0d done=%0b expected %b/%0d/1",
                     s_chain, s_bit_count, s_done, exp_img, SL);
        end
    endtask

    task automatic test_rst_mid();
        int wi, cyc;
        fill_random();
        wi = 0; cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (int'(bit_count) != 20 && cyc < 100) begin
            din_valid = 1'b1;
            din = words[wi];
            if (din_ready) wi++;
            @(negedge clk);
            cyc++;
        end
        din_valid = 1'b0;
        n_cmp++;
        if (int'(bit_count) != 20) begin
            n_bad++;
            $display("FAIL rst_mid_reach: bit_count=%0d expected 20", bit_count);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (chain_en !== 1'b0 || busy !== 1'b0 || bit_count !== 7'd0 || din_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: chain_en=%0b busy=%0b bit_count=%0d din_ready=%0b expected 0/0/0/0",
                     chain_en, busy, bit_count, din_ready);
        end
        rst = 1'b0;
        fill_random();
        run_load(99, 0, -1, 1'b0);
    endtask

    task automatic test_mid_start();
        fill_random();
        run_load(99, 0, 30, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_load($urandom_range(1, 15), $urandom_range(1, 4), -1, 1'b0);
        end
    endtask

`ifdef PROG_CRC_EN
    task automatic test_crc();
        for (int i = 0; i < 16; i++) words[i] = 4'hF;
        stuck = 1'b1;
        run_load(99, 0, -1, 1'b1);
        stuck = 1'b0;
        fill_random();
        run_load(99, 0, -1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_short_chain();
        test_rst_mid();
        test_mid_start();
        test_random();
`ifdef PROG_CRC_EN
        test_crc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
